// File: rtl/key_entry_ctrl.sv
// Two-digit decimal entry controller between the keypad scanner and the segment display.
// Handles digit entry, backspace, clear, enter, edit blinking and stale-entry timeout.
module key_entry_ctrl #(
  parameter int TIMEOUT_CYC = 60_000_000,
  parameter int BLINK_CYC   = 3_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] key_pulse,
  output logic [7:0]  seg_data,
  output logic [1:0]  digit_on,
  output logic [6:0]  value,
  output logic        value_valid,
  output logic        err,
  output logic        busy
);

  // state  | meaning
  // IDLE   | no entry in progress, committed value shown
  // ENTRY1 | one digit entered (units), tens blank
  // ENTRY2 | two digits entered, waiting for enter/backspace/clear
  typedef enum logic [1:0] {S_IDLE, S_ENTRY1, S_ENTRY2} state_t;

  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYC - 1);

  state_t        state, state_n;
  logic [3:0]    ent_t, ent_t_n, ent_u, ent_u_n;
  logic [3:0]    com_t, com_t_n, com_u, com_u_n;
  logic          has_val, has_val_n;
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic [BW-1:0] bl_cnt, bl_cnt_n;
  logic          phase, phase_n;
  logic [7:0]    seg_data_n;
  logic [1:0]    digit_on_n;
  logic [6:0]    value_n;
  logic          valid_n, err_n, busy_n;

  logic          key_hit;
  logic [3:0]    key_idx;
  logic          is_digit, is_bksp, is_clr, is_ent;

  // Lowest set bit wins when several keys strobe together.
  always_comb begin
    key_hit = |key_pulse;
    key_idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (key_pulse[i]) key_idx = 4'(i);
    end
    is_digit = key_hit && (key_idx <= 4'd9);
    is_bksp  = key_hit && (key_idx == 4'd10);
    is_clr   = key_hit && (key_idx == 4'd11);
    is_ent   = key_hit && (key_idx == 4'd12);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      ent_t       <= 4'd0;
      ent_u       <= 4'd0;
      com_t       <= 4'd0;
      com_u       <= 4'd0;
      has_val     <= 1'b0;
      to_cnt      <= '0;
      bl_cnt      <= '0;
      phase       <= 1'b1;
      seg_data    <= 8'h00;
      digit_on    <= 2'b00;
      value       <= 7'd0;
      value_valid <= 1'b0;
      err         <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      ent_t       <= ent_t_n;
      ent_u       <= ent_u_n;
      com_t       <= com_t_n;
      com_u       <= com_u_n;
      has_val     <= has_val_n;
      to_cnt      <= to_cnt_n;
      bl_cnt      <= bl_cnt_n;
      phase       <= phase_n;
      seg_data    <= seg_data_n;
      digit_on    <= digit_on_n;
      value       <= value_n;
      value_valid <= valid_n;
      err         <= err_n;
      busy        <= busy_n;
    end
  end

  always_comb begin
    state_n   = state;
    ent_t_n   = ent_t;
    ent_u_n   = ent_u;
    com_t_n   = com_t;
    com_u_n   = com_u;
    has_val_n = has_val;
    value_n   = value;
    valid_n   = 1'b0;
    err_n     = 1'b0;

    case (state)
      S_IDLE: begin
        if (is_digit) begin
          state_n = S_ENTRY1;
          ent_t_n = 4'd0;
          ent_u_n = key_idx;
        end else if (is_ent) begin
          err_n = 1'b1;
        end
      end
      S_ENTRY1: begin
        if (is_digit) begin
          state_n = S_ENTRY2;
          ent_t_n = ent_u;
          ent_u_n = key_idx;
        end else if (is_bksp || is_clr) begin
          state_n = S_IDLE;
        end else if (is_ent) begin
          state_n   = S_IDLE;
          value_n   = 7'(ent_u);
          valid_n   = 1'b1;
          com_t_n   = 4'd0;
          com_u_n   = ent_u;
          has_val_n = 1'b1;
        end
      end
      S_ENTRY2: begin
        if (is_digit) begin
          err_n = 1'b1;
        end else if (is_bksp) begin
          state_n = S_ENTRY1;
          ent_u_n = ent_t;
        end else if (is_clr) begin
          state_n = S_IDLE;
        end else if (is_ent) begin
          state_n   = S_IDLE;
          value_n   = 7'(ent_t) * 7'd10 + 7'(ent_u);
          valid_n   = 1'b1;
          com_t_n   = ent_t;
          com_u_n   = ent_u;
          has_val_n = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // Any key (even an ignored one) keeps the entry alive.
    if (!key_hit && state != S_IDLE && to_cnt == TO_LAST) begin
      state_n = S_IDLE;
      err_n   = 1'b1;
    end
  end

  always_comb begin
    to_cnt_n = to_cnt;
    bl_cnt_n = bl_cnt;
    phase_n  = phase;

    if (key_hit || state_n == S_IDLE) to_cnt_n = '0;
    else if (to_cnt != TO_LAST)       to_cnt_n = to_cnt + 1'b1;

    if (key_hit || state_n == S_IDLE) begin
      bl_cnt_n = '0;
      phase_n  = 1'b1;
    end else if (bl_cnt == BL_LAST) begin
      bl_cnt_n = '0;
      phase_n  = ~phase;
    end else begin
      bl_cnt_n = bl_cnt + 1'b1;
    end
  end

  // Display is derived from next-state values so it lines up with the key edge.
  always_comb begin
    seg_data_n = {com_t_n, com_u_n};
    digit_on_n = has_val_n ? 2'b11 : 2'b00;
    busy_n     = (state_n != S_IDLE);
    case (state_n)
      S_ENTRY1: begin
        seg_data_n = {4'h0, ent_u_n};
        digit_on_n = {1'b0, phase_n};
      end
      S_ENTRY2: begin
        seg_data_n = {ent_t_n, ent_u_n};
        digit_on_n = {phase_n, phase_n};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Directed bench for key_entry_ctrl with short timeout/blink parameters.
module tb_key_entry_ctrl;
  logic        clk;
  logic        rst;
  logic [15:0] key_pulse;
  logic [7:0]  seg_data;
  logic [1:0]  digit_on;
  logic [6:0]  value;
  logic        value_valid;
  logic        err;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [15:0] K_BKSP = 16'h0400;
  localparam logic [15:0] K_CLR  = 16'h0800;
  localparam logic [15:0] K_ENT  = 16'h1000;

  key_entry_ctrl #(.TIMEOUT_CYC(20), .BLINK_CYC(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_pulse   (key_pulse),
    .seg_data    (seg_data),
    .digit_on    (digit_on),
    .value       (value),
    .value_valid (value_valid),
    .err         (err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns at the falling edge after the sampling edge.
  task automatic send(input logic [15:0] pat);
    @(negedge clk);
    key_pulse = pat;
    @(negedge clk);
    key_pulse = 16'h0000;
  endtask

  task automatic digit(input int d);
    logic [15:0] p;
    p = 16'h0001 << d;
    send(p);
  endtask

  initial begin
    rst = 1'b1;
    key_pulse = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_seg", seg_data, 8'h00);
    chk("rst_don", digit_on, 2'b00);
    chk("rst_val", value, 7'd0);
    chk("rst_vv", value_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // 4,7,ENT -> 47
    digit(4);
    chk("e1_busy", busy, 1'b1);
    chk("e1_seg", seg_data, 8'h04);
    chk("e1_don", digit_on, 2'b01);
    digit(7);
    chk("e2_seg", seg_data, 8'h47);
    chk("e2_don", digit_on, 2'b11);
    send(K_ENT);
    chk("c47_val", value, 7'd47);
    chk("c47_vv", value_valid, 1'b1);
    chk("c47_seg", seg_data, 8'h47);
    chk("c47_don", digit_on, 2'b11);
    chk("c47_busy", busy, 1'b0);
    @(negedge clk);
    chk("c47_vv_drop", value_valid, 1'b0);

    // 3,ENT commits from ENTRY1
    digit(3);
    send(K_ENT);
    chk("c3_val", value, 7'd3);
    chk("c3_seg", seg_data, 8'h03);
    chk("c3_vv", value_valid, 1'b1);

    // 9,BKSP,BKSP -> back to IDLE showing 03
    digit(9);
    chk("b_seg9", seg_data, 8'h09);
    send(K_BKSP);
    chk("b_busy1", busy, 1'b0);
    send(K_BKSP);
    chk("b_busy2", busy, 1'b0);
    chk("b_seg", seg_data, 8'h03);
    chk("b_don", digit_on, 2'b11);
    chk("b_err", err, 1'b0);

    // 1,2,5 -> third digit rejected
    digit(1);
    digit(2);
    digit(5);
    chk("r_err", err, 1'b1);
    chk("r_seg", seg_data, 8'h12);
    chk("r_busy", busy, 1'b1);
    @(negedge clk);
    chk("r_err_drop", err, 1'b0);
    send(K_BKSP);
    chk("r_bk_seg", seg_data, 8'h01);
    chk("r_bk_don", digit_on, 2'b01);
    chk("r_bk_busy", busy, 1'b1);

    // ENTRY2 {1,6}; CLR+ENT together -> CLR wins
    digit(6);
    chk("ce_pre", seg_data, 8'h16);
    send(K_CLR | K_ENT);
    chk("ce_busy", busy, 1'b0);
    chk("ce_vv", value_valid, 1'b0);
    chk("ce_val", value, 7'd3);
    chk("ce_seg", seg_data, 8'h03);

    // BKSP+CLR together -> BKSP wins (lower index)
    digit(2);
    digit(4);
    send(K_BKSP | K_CLR);
    chk("bc_busy", busy, 1'b1);
    chk("bc_seg", seg_data, 8'h02);
    send(K_CLR);
    chk("bc_clr", busy, 1'b0);

    // ENT in IDLE -> err, value kept
    send(K_ENT);
    chk("ie_err", err, 1'b1);
    chk("ie_vv", value_valid, 1'b0);
    chk("ie_val", value, 7'd3);

    // keys 13-15 ignored without err
    send(16'hE000);
    chk("ig_err", err, 1'b0);
    chk("ig_busy", busy, 1'b0);

    // 9,9,ENT -> 99
    digit(9);
    digit(9);
    send(K_ENT);
    chk("c99_val", value, 7'd99);
    chk("c99_seg", seg_data, 8'h99);

    // Timeout: key 8, then 20 key-free cycles
    digit(8);
    repeat (19) @(negedge clk);
    chk("to_early_err", err, 1'b0);
    chk("to_early_busy", busy, 1'b1);
    @(negedge clk);
    chk("to_err", err, 1'b1);
    chk("to_busy", busy, 1'b0);
    chk("to_val", value, 7'd99);
    chk("to_vv", value_valid, 1'b0);
    chk("to_seg", seg_data, 8'h99);
    @(negedge clk);
    chk("to_err_drop", err, 1'b0);

    // Blink with period 4: on for cycles 0-3 after key, off 4-7, on at 8
    digit(5);
    chk("bl_k", digit_on, 2'b01);
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      chk($sformatf("bl_%0d", i), {31'd0, digit_on[0]}, {31'd0, ((i / 4) % 2) == 0});
      chk($sformatf("bl_t%0d", i), {31'd0, digit_on[1]}, 32'd0);
    end
    // advance into an off phase, then a key forces digits on and restarts
    repeat (3) @(negedge clk);
    chk("bl_off", digit_on, 2'b00);
    digit(7);
    chk("bl_key_on", digit_on, 2'b11);
    chk("bl_key_seg", seg_data, 8'h57);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("bl2_%0d", i), {30'd0, digit_on}, (i < 4) ? 32'd3 : 32'd0);
    end
    send(K_CLR);

    // Reset mid-entry
    digit(3);
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", busy, 1'b0);
    chk("mr_val", value, 7'd0);
    chk("mr_seg", seg_data, 8'h00);
    chk("mr_don", digit_on, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    send(K_ENT);
    chk("mr_ent_err", err, 1'b1);
    chk("mr_ent_don", digit_on, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
